wb_pwm_led: RTL and testbench

// Wishbone-slave PWM LED driver, generalised to CHANNELS outputs of PWM_W-bit duty resolution.

---
 rtl/wb_pwm_led_if.sv | 30 +++
 rtl/wb_pwm_led.sv | 182 ++++++++++++++++++
 tb/tb_wb_pwm_led.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pwm_led_if.sv
// Wishbone slave bus bundle for wb_pwm_led.
// Signals: wb_stb_i strobe, wb_we_i write enable, wb_adr_i word index,
//          wb_dat_i write data, wb_dat_o read data, wb_ack_o one-cycle acknowledge.
// Signal names keep the slave-side _i/_o suffixes so they match the peripheral's pinout.
interface wb_pwm_led_if;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_stb_i,
        output wb_we_i,
        output wb_adr_i,
        output wb_dat_i,
        input  wb_dat_o,
        input  wb_ack_o
    );

    modport slave (
        input  wb_stb_i,
        input  wb_we_i,
        input  wb_adr_i,
        input  wb_dat_i,
        output wb_dat_o,
        output wb_ack_o
    );
endinterface

// File: rtl/wb_pwm_led.sv
// Wishbone-slave PWM LED driver with CHANNELS outputs of PWM_W-bit duty resolution.
// A 16-bit prescaler produces PWM ticks; a PWM_W-bit period counter runs 0..2**PWM_W-2.
// Live duties only change at period ends (glitch-free), either jumping to the target or,
// in fade mode, stepping one LSB toward it every FADEDIV+1 periods.
// Ports:
//   clk_i  system clock
//   rst_i  synchronous reset, active high
//   wb     Wishbone slave bundle (strobe, we, address, data in/out, ack)
//   pwm_o  registered PWM outputs, 1 = LED on
// Register map (word index): 0 CTRL {FADE,EN}, 1 PRESC, 2 FADEDIV,
//   4+n TARGET n (write target, read live duty). Other indices read 0, still acked.
module wb_pwm_led #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned PWM_W    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    wb_pwm_led_if.slave         wb,
    output logic [CHANNELS-1:0] pwm_o
);
    localparam int unsigned DIV_W = 16;
    localparam logic [3:0]  ADR_CTRL    = 4'h0;
    localparam logic [3:0]  ADR_PRESC   = 4'h1;
    localparam logic [3:0]  ADR_FADEDIV = 4'h2;

    typedef logic [PWM_W-1:0] duty_t;

    // Last counter value of a period: 2**PWM_W-2, giving 2**PWM_W-1 ticks per period.
    localparam duty_t CNT_LAST = duty_t'((1 << PWM_W) - 2);

    logic                     ack_q, ack_d;
    logic [31:0]              dat_q, dat_d;
    logic                     en_q, en_d;
    logic                     fade_q, fade_d;
    logic [DIV_W-1:0]         presc_q, presc_d;
    logic [DIV_W-1:0]         fadediv_q, fadediv_d;
    logic [DIV_W-1:0]         pre_q, pre_d;
    logic [DIV_W-1:0]         fcnt_q, fcnt_d;
    duty_t                    cnt_q, cnt_d;
    duty_t [CHANNELS-1:0]     target_q, target_d;
    duty_t [CHANNELS-1:0]     live_q, live_d;
    logic [CHANNELS-1:0]      pwm_q, pwm_d;

    logic                     access;
    logic                     tick;
    logic                     period_end;
    logic                     fade_step;
    logic [31:0]              rd_val;
    logic                     unused_dat;

    // A strobe is taken only when no ack is outstanding, so back-to-back strobes ack every other cycle.
    assign access     = wb.wb_stb_i && !ack_q;
    assign tick       = en_q && (pre_q == presc_q);
    assign period_end = tick && (cnt_q == CNT_LAST);
    assign fade_step  = period_end && fade_q && (fcnt_q == fadediv_q);
    assign unused_dat = ^wb.wb_dat_i[31:DIV_W];

    // Read data mux; TARGET slots return the live duty.
    always_comb begin
        rd_val = '0;
        case (wb.wb_adr_i)
            ADR_CTRL:    rd_val = {30'd0, fade_q, en_q};
            ADR_PRESC:   rd_val = {16'd0, presc_q};
            ADR_FADEDIV: rd_val = {16'd0, fadediv_q};
            default: begin
                for (int unsigned n = 0; n < CHANNELS; n++) begin
                    if (wb.wb_adr_i == 4'(4 + n)) begin
                        rd_val = 32'(live_q[n]);
                    end
                end
            end
        endcase
    end

    // Next-state logic for bus, timebase, duty updates and register writes.
    always_comb begin
        ack_d     = access;
        dat_d     = '0;
        en_d      = en_q;
        fade_d    = fade_q;
        presc_d   = presc_q;
        fadediv_d = fadediv_q;
        pre_d     = pre_q;
        fcnt_d    = fcnt_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        live_d    = live_q;
        pwm_d     = '0;

        if (access && !wb.wb_we_i) begin
            dat_d = rd_val;
        end

        // Prescaler: free 16-bit count, so a PRESC below the current count wraps through 0xFFFF.
        if (!en_q || tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 16'd1;
        end

        if (!en_q) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + duty_t'(1);
        end

        // Fade counter counts period ends and idles at 0 unless fading while enabled.
        if (!en_q || !fade_q) begin
            fcnt_d = '0;
        end else if (period_end) begin
            fcnt_d = (fcnt_q == fadediv_q) ? '0 : fcnt_q + 16'd1;
        end

        for (int unsigned n = 0; n < CHANNELS; n++) begin
            pwm_d[n] = en_q && (cnt_q < live_q[n]);
            if (period_end && !fade_q) begin
                live_d[n] = target_q[n];
            end else if (fade_step) begin
                if (live_q[n] < target_q[n]) begin
                    live_d[n] = live_q[n] + duty_t'(1);
                end else if (live_q[n] > target_q[n]) begin
                    live_d[n] = live_q[n] - duty_t'(1);
                end
            end
        end

        // Register writes land on the same edge that raises ack; a target written at a
        // period end is picked up only at the following one.
        if (access && wb.wb_we_i) begin
            case (wb.wb_adr_i)
                ADR_CTRL: begin
                    en_d   = wb.wb_dat_i[0];
                    fade_d = wb.wb_dat_i[1];
                end
                ADR_PRESC:   presc_d   = wb.wb_dat_i[DIV_W-1:0];
                ADR_FADEDIV: fadediv_d = wb.wb_dat_i[DIV_W-1:0];
                default: begin
                    for (int unsigned n = 0; n < CHANNELS; n++) begin
                        if (wb.wb_adr_i == 4'(4 + n)) begin
                            target_d[n] = wb.wb_dat_i[PWM_W-1:0];
                        end
                    end
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            en_q      <= 1'b0;
            fade_q    <= 1'b0;
            presc_q   <= '0;
            fadediv_q <= '0;
            pre_q     <= '0;
            fcnt_q    <= '0;
            cnt_q     <= '0;
            target_q  <= '0;
            live_q    <= '0;
            pwm_q     <= '0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            en_q      <= en_d;
            fade_q    <= fade_d;
            presc_q   <= presc_d;
            fadediv_q <= fadediv_d;
            pre_q     <= pre_d;
            fcnt_q    <= fcnt_d;
            cnt_q     <= cnt_d;
            target_q  <= target_d;
            live_q    <= live_d;
            pwm_q     <= pwm_d;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign pwm_o       = pwm_q;
endmodule

// File: tb/tb_wb_pwm_led.sv
// Testbench for wb_pwm_led: directed scenarios plus randomized bus traffic, checked every
// cycle against a behavioural model of the register/tick/period/duty rules.
module tb_wb_pwm_led;
    localparam int unsigned CH     = 3;
    localparam int unsigned W      = 8;
    localparam int          PERIOD = (1 << W) - 1;
    localparam int          LAST   = PERIOD - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] pwm;
    wb_pwm_led_if  bus();

    wb_pwm_led #(.CHANNELS(CH), .PWM_W(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (bus),
        .pwm_o (pwm)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // Behavioural model state (post-edge values).
    bit            m_en, m_fade, m_ack;
    int            m_presc, m_fdiv, m_pre, m_cnt, m_fc;
    int            m_tgt [CH];
    int            m_live[CH];
    logic [31:0]   m_dat;
    logic [CH-1:0] m_pwm;
    int            pe_count = 0;

    bit            acc, tick, pe;
    logic [31:0]   nx_dat;
    logic [CH-1:0] nx_pwm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        int ai;
        ai = int'(a);
        case (ai)
            0: return {30'd0, m_fade, m_en};
            1: return 32'(m_presc);
            2: return 32'(m_fdiv);
            default: begin
                if (ai >= 4 && ai < 4 + CH) return 32'(m_live[ai-4]);
                return 32'd0;
            end
        endcase
    endfunction

    // Model: every clock apply the rules to the pre-edge state, then commit.
    always @(posedge clk) begin
        if (rst) begin
            m_en = 0; m_fade = 0; m_ack = 0; m_presc = 0; m_fdiv = 0;
            m_pre = 0; m_cnt = 0; m_fc = 0; m_dat = '0; m_pwm = '0;
            for (int n = 0; n < CH; n++) begin
                m_tgt[n] = 0;
                m_live[n] = 0;
            end
        end else begin
            acc    = bus.wb_stb_i && !m_ack;
            nx_dat = (acc && !bus.wb_we_i) ? model_read(bus.wb_adr_i) : 32'd0;
            tick   = m_en && (m_pre == m_presc);
            pe     = tick && (m_cnt == LAST);
            for (int n = 0; n < CH; n++) nx_pwm[n] = m_en && (m_cnt < m_live[n]);
            if (pe) begin
                pe_count++;
                for (int n = 0; n < CH; n++) begin
                    if (!m_fade) m_live[n] = m_tgt[n];
                    else if (m_fc == m_fdiv) m_live[n] += (m_live[n] < m_tgt[n]) ? 1 :
                                                          (m_live[n] > m_tgt[n]) ? -1 : 0;
                end
            end
            m_fc  = (!m_en || !m_fade) ? 0 : (pe ? ((m_fc == m_fdiv) ? 0 : m_fc + 1) : m_fc);
            m_pre = !m_en ? 0 : (tick ? 0 : (m_pre + 1) % 65536);
            m_cnt = !m_en ? 0 : (tick ? (m_cnt + 1) % PERIOD : m_cnt);
            if (acc && bus.wb_we_i) begin
                case (int'(bus.wb_adr_i))
                    0: begin m_en = bus.wb_dat_i[0]; m_fade = bus.wb_dat_i[1]; end
                    1: m_presc = int'(bus.wb_dat_i[15:0]);
                    2: m_fdiv  = int'(bus.wb_dat_i[15:0]);
                    default: begin
                        for (int n = 0; n < CH; n++)
                            if (int'(bus.wb_adr_i) == 4 + n) m_tgt[n] = int'(bus.wb_dat_i[W-1:0]);
                    end
                endcase
            end
            m_ack = acc;
            m_dat = nx_dat;
            m_pwm = nx_pwm;
        end
    end

    // Cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("ack", 32'(bus.wb_ack_o), 32'(m_ack));
            check("dat", bus.wb_dat_o, m_dat);
            check("pwm", 32'(pwm), 32'(m_pwm));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1; bus.wb_adr_i = a; bus.wb_dat_i = d;
        @(posedge clk); #1;
        bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        idle(1);
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
        bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = a;
        @(posedge clk); #1;
        bus.wb_stb_i = 1'b0;
        @(negedge clk);
        d = bus.wb_dat_o;
        check("read_ack", 32'(bus.wb_ack_o), 32'd1);
        idle(1);
    endtask

    task automatic read_expect(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(a, d);
        check(name, d, exp);
    endtask

    task automatic wait_cnt(input int v);
        int k = 0;
        while (m_cnt != v && k < 5000) begin idle(1); k++; end
        check("wait_cnt_reached", 32'(m_cnt == v), 32'd1);
    endtask

    task automatic wait_pe(input int k);
        int goal = pe_count + k;
        int lim  = k * 1100 + 10;
        int c    = 0;
        while (pe_count < goal && c < lim) begin idle(1); c++; end
        check("wait_pe_reached", 32'(pe_count >= goal), 32'd1);
    endtask

    task automatic count_high(input int len, output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        repeat (len) begin
            @(negedge clk);
            c0 += int'(pwm[0]); c1 += int'(pwm[1]); c2 += int'(pwm[2]);
        end
        idle(1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, r, a, h, g;
        logic [31:0] d;
        rst = 1'b1;
        bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0; bus.wb_adr_i = '0; bus.wb_dat_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_pwm", 32'(pwm), 32'd0);
        check("reset_ack", 32'(bus.wb_ack_o), 32'd0);
        idle(1);
        for (int i = 0; i <= 6; i++) read_expect("reset_read", 4'(i), 32'd0);

        // Static duties.
        wb_write(4'h1, 32'd0);
        wb_write(4'h4, 32'h40);
        wb_write(4'h5, 32'hFF);
        wb_write(4'h6, 32'h00);
        wb_write(4'h0, 32'd1);
        idle(300);
        count_high(PERIOD, c0, c1, c2);
        check("static_hi0", 32'(c0), 32'd64);
        check("static_hi1", 32'(c1), 32'd255);
        check("static_hi2", 32'(c2), 32'd0);

        // Prescaled timebase.
        wb_write(4'h4, 32'h10);
        wb_write(4'h1, 32'd3);
        idle(2100);
        count_high(4 * PERIOD, c0, c1, c2);
        check("presc_hi0", 32'(c0), 32'd64);
        check("presc_hi1", 32'(c1), 32'd1020);

        // Glitch-free duty change.
        wb_write(4'h0, 32'd0);
        wb_write(4'h1, 32'd0);
        wb_write(4'h4, 32'h40);
        wb_write(4'h0, 32'd1);
        wait_pe(1);
        wait_cnt(100);
        wb_write(4'h4, 32'h80);
        read_expect("glitch_before", 4'h4, 32'h40);
        wait_pe(1);
        read_expect("glitch_after", 4'h4, 32'h80);
        count_high(PERIOD, c0, c1, c2);
        check("glitch_hi0", 32'(c0), 32'd128);

        // Disable mid-period.
        wait_cnt(200);
        wb_write(4'h0, 32'd0);
        @(negedge clk);
        check("disable_pwm", 32'(pwm), 32'd0);
        idle(1);
        read_expect("disable_live0", 4'h4, 32'h80);
        read_expect("disable_live1", 4'h5, 32'hFF);
        read_expect("disable_ctrl", 4'h0, 32'd0);

        // Fade up and down.
        wb_write(4'h4, 32'd0);
        wb_write(4'h0, 32'd1);
        wait_pe(1);
        read_expect("fade_start", 4'h4, 32'd0);
        wb_write(4'h2, 32'd1);
        wait_cnt(10);
        wb_write(4'h0, 32'd3);
        wb_write(4'h4, 32'd4);
        for (int v = 1; v <= 4; v++) begin
            wait_pe(2);
            read_expect("fade_up", 4'h4, 32'(v));
        end
        wait_pe(2);
        read_expect("fade_hold", 4'h4, 32'd4);
        wb_write(4'h4, 32'd0);
        for (int v = 3; v >= 0; v--) begin
            wait_pe(2);
            read_expect("fade_down", 4'h4, 32'(v));
        end
        wb_write(4'h4, 32'h30);
        wait_pe(2);
        read_expect("fade_restart", 4'h4, 32'd1);

        // Reset mid-fade with a read in flight.
        rst = 1'b1;
        bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 4'h4;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.wb_stb_i = 1'b0;
        @(negedge clk);
        check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
        check("rst_pwm", 32'(pwm), 32'd0);
        idle(1);
        for (int i = 0; i <= 6; i++) read_expect("rst_read", 4'(i), 32'd0);

        // Randomized traffic, PRESC kept fixed to avoid long prescaler wraps.
        wb_write(4'h1, 32'd1);
        wb_write(4'h0, 32'd1);
        for (int i = 0; i < 1200; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end else begin
                a = $urandom_range(0, 15);
                d = $urandom();
                if (a == 0) d[0] = ($urandom_range(0, 3) != 0);
                if (a == 2) d[15:0] = 16'($urandom_range(0, 2));
                bus.wb_adr_i = 4'(a);
                bus.wb_we_i  = (a == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                bus.wb_dat_i = d;
                bus.wb_stb_i = 1'b1;
                h = $urandom_range(1, 4);
                g = $urandom_range(0, 3);
                idle(h);
                bus.wb_stb_i = 1'b0;
                bus.wb_we_i  = 1'b0;
                if (g > 0) idle(g);
            end
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
